// File: rtl/chan_regf.sv
// chan_regf: multi-channel register file behind a 32-bit single-cycle bus.
// Each channel has four words: CTRL, STAT (sticky W1C irq), RX (core-driven)
// and TX (bus-written). Reads are registered with a one-cycle latency.
// Illegal accesses raise an error pulse and have no side effect.

module chan_regf #(
   parameter int chan_p  = 4,
   parameter int width_p = 8
) (
   input  logic                       main_clk_i,
   input  logic                       main_rst_an_i,
   input  logic                       mem_ena_i,
   input  logic [12:0]                mem_addr_i,
   input  logic                       mem_wena_i,
   input  logic [31:0]                mem_wdata_i,
   output logic [31:0]                mem_rdata_o,
   output logic                       mem_rvld_o,
   output logic                       mem_err_o,
   output logic [chan_p-1:0]          ctrl_ena_o,
   input  logic [chan_p-1:0]          busy_i,
   input  logic [chan_p-1:0]          irq_set_i,
   output logic                       irq_o,
   input  logic [chan_p*width_p-1:0]  rx_data_i,
   output logic [chan_p*width_p-1:0]  tx_data_o,
   output logic [chan_p-1:0]          tx_upd_o
);

   // Word offset inside a channel's 16-byte window.
   typedef enum logic [1:0] {
      WORD_CTRL = 2'd0,
      WORD_STAT = 2'd1,
      WORD_RX   = 2'd2,
      WORD_TX   = 2'd3
   } word_e;

   localparam logic [8:0] CHAN_CNT = 9'(chan_p);

   // Address decode
   logic [8:0] ch_idx;
   word_e      word;
   logic       addr_unaligned;
   logic       chan_bad;
   logic       wr_ro;
   logic       acc_err;
   logic       wr_ok;
   logic       rd_ok;

   assign ch_idx         = mem_addr_i[12:4];
   assign word           = word_e'(mem_addr_i[3:2]);
   assign addr_unaligned = |mem_addr_i[1:0];
   assign chan_bad       = (ch_idx >= CHAN_CNT);
   assign wr_ro          = mem_wena_i && (word == WORD_RX);
   assign acc_err        = addr_unaligned | chan_bad | wr_ro;
   assign wr_ok          = mem_ena_i & mem_wena_i & ~acc_err;
   assign rd_ok          = mem_ena_i & ~mem_wena_i & ~acc_err;

   // Register state
   logic [chan_p-1:0]         ena_q;
   logic [chan_p-1:0]         irq_en_q;
   logic [chan_p-1:0]         irq_q;
   logic [chan_p*width_p-1:0] tx_q;
   logic [chan_p-1:0]         tx_upd_q;

   // Read pipeline state
   logic [31:0] rdata_q;
   logic        rvld_q;
   logic        err_q;

   // Per-channel write strobes and the combinational read mux result
   logic [chan_p-1:0] ctrl_we;
   logic [chan_p-1:0] stat_we;
   logic [chan_p-1:0] tx_we;
   logic [chan_p-1:0] irq_clr;
   logic [31:0]       rd_data;

   // Upper write-data bits beyond the implemented fields are intentionally ignored.
   logic unused_wdata;
   assign unused_wdata = ^mem_wdata_i;

   // Decode a legal write into one strobe per channel and word.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can
      // leave it unassigned and infer a latch.
      ctrl_we = '0;
      stat_we = '0;
      tx_we   = '0;
      for (int c = 0; c < chan_p; c++) begin
         if (wr_ok && (ch_idx == 9'(c))) begin
            case (word)
               WORD_CTRL: ctrl_we[c] = 1'b1;
               WORD_STAT: stat_we[c] = 1'b1;
               WORD_TX:   tx_we[c]   = 1'b1;
               default:   ;
            endcase
         end
      end
   end

   // W1C clear request per channel; only bit 0 of the write data clears.
   assign irq_clr = stat_we & {chan_p{mem_wdata_i[0]}};

   // Select the addressed word for a read; unused bits stay zero.
   always_comb begin
      rd_data = '0;
      for (int c = 0; c < chan_p; c++) begin
         if (ch_idx == 9'(c)) begin
            case (word)
               WORD_CTRL: rd_data[2:0]         = {busy_i[c], irq_en_q[c], ena_q[c]};
               WORD_STAT: rd_data[0]           = irq_q[c];
               WORD_RX:   rd_data[width_p-1:0] = rx_data_i[c*width_p +: width_p];
               WORD_TX:   rd_data[width_p-1:0] = tx_q[c*width_p +: width_p];
               default:   ;
            endcase
         end
      end
   end

   // Channel registers: CTRL fields, sticky irq, TX data and TX update strobe.
   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      // NOTE: every flop here is reset asynchronously; there is no storage array
      // left uninitialised, so outputs are defined from the first reset onward.
      if (!main_rst_an_i) begin
         ena_q    <= '0;
         irq_en_q <= '0;
         irq_q    <= '0;
         tx_q     <= '0;
         tx_upd_q <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every flop
         // samples values from before this edge, regardless of statement order.
         for (int c = 0; c < chan_p; c++) begin
            if (ctrl_we[c]) begin
               ena_q[c]    <= mem_wdata_i[0];
               irq_en_q[c] <= mem_wdata_i[1];
            end
            if (tx_we[c]) begin
               tx_q[c*width_p +: width_p] <= mem_wdata_i[width_p-1:0];
            end
         end
         // A set event in the same cycle as a clear wins.
         irq_q    <= irq_set_i | (irq_q & ~irq_clr);
         tx_upd_q <= tx_we;
      end
   end

   // Registered read response and error pulse, one cycle after the request.
   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i) begin
         rdata_q <= '0;
         rvld_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         rvld_q  <= mem_ena_i & ~mem_wena_i;
         err_q   <= mem_ena_i & acc_err;
         rdata_q <= rd_ok ? rd_data : 32'h0;
      end
   end

   assign mem_rdata_o = rdata_q;
   assign mem_rvld_o  = rvld_q;
   assign mem_err_o   = err_q;
   assign ctrl_ena_o  = ena_q;
   assign tx_data_o   = tx_q;
   assign tx_upd_o    = tx_upd_q;
   assign irq_o       = |(irq_q & irq_en_q);

endmodule

// File: tb/tb_chan_regf.sv
// Testbench for chan_regf (chan_p=4, width_p=8): directed cases followed by
// random traffic, checked by a scoreboard against a word-level model.

module tb_chan_regf;

   localparam int CH = 4;
   localparam int W  = 8;

   logic            main_clk_i    = 1'b0;
   logic            main_rst_an_i = 1'b0;
   logic            mem_ena_i     = 1'b0;
   logic [12:0]     mem_addr_i    = '0;
   logic            mem_wena_i    = 1'b0;
   logic [31:0]     mem_wdata_i   = '0;
   logic [31:0]     mem_rdata_o;
   logic            mem_rvld_o;
   logic            mem_err_o;
   logic [CH-1:0]   ctrl_ena_o;
   logic [CH-1:0]   busy_i        = '0;
   logic [CH-1:0]   irq_set_i     = '0;
   logic            irq_o;
   logic [CH*W-1:0] rx_data_i     = '0;
   logic [CH*W-1:0] tx_data_o;
   logic [CH-1:0]   tx_upd_o;

   chan_regf #(.chan_p(CH), .width_p(W)) dut (
      .main_clk_i    (main_clk_i),
      .main_rst_an_i (main_rst_an_i),
      .mem_ena_i     (mem_ena_i),
      .mem_addr_i    (mem_addr_i),
      .mem_wena_i    (mem_wena_i),
      .mem_wdata_i   (mem_wdata_i),
      .mem_rdata_o   (mem_rdata_o),
      .mem_rvld_o    (mem_rvld_o),
      .mem_err_o     (mem_err_o),
      .ctrl_ena_o    (ctrl_ena_o),
      .busy_i        (busy_i),
      .irq_set_i     (irq_set_i),
      .irq_o         (irq_o),
      .rx_data_i     (rx_data_i),
      .tx_data_o     (tx_data_o),
      .tx_upd_o      (tx_upd_o)
   );

   always #5 main_clk_i = ~main_clk_i;

   int cyc = 0;
   always @(posedge main_clk_i) cyc <= cyc + 1;

   // Expected DUT outputs for one cycle.
   typedef struct {
      int          cyc;
      bit          rvld;
      bit          err;
      logic [31:0] rdata;
      logic [3:0]  ena;
      bit          irq;
      logic [31:0] tx;
      logic [3:0]  upd;
   } exp_t;

   exp_t sb_q[$];

   // Reference model: architectural register contents per channel.
   bit       m_ena [CH];
   bit       m_ien [CH];
   bit       m_irq [CH];
   bit [7:0] m_tx  [CH];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_ena[c] = 0;
         m_ien[c] = 0;
         m_irq[c] = 0;
         m_tx[c]  = '0;
      end
   endtask

   // Drive one cycle of stimulus, predict the response, and advance past the edge.
   task automatic step(input bit ena, input bit wena, input logic [12:0] addr,
                       input logic [31:0] wdata, input logic [3:0] iset);
      exp_t e;
      int   ch;
      int   off;
      bit   err;
      bit   clr;
      mem_ena_i   = ena;
      mem_wena_i  = wena;
      mem_addr_i  = addr;
      mem_wdata_i = wdata;
      irq_set_i   = iset;
      busy_i      = 4'($urandom);
      rx_data_i   = $urandom;

      ch  = int'(addr) / 16;
      off = int'(addr) % 16;
      err = ena && ((off % 4) != 0 || ch >= CH || (wena && off == 8));

      e.cyc   = cyc + 1;
      e.rvld  = ena && !wena;
      e.err   = err;
      e.rdata = 32'h0;
      e.upd   = 4'h0;
      if (ena && !wena && !err) begin
         case (off)
            0:  e.rdata = {29'h0, busy_i[ch], m_ien[ch], m_ena[ch]};
            4:  e.rdata = {31'h0, m_irq[ch]};
            8:  e.rdata = {24'h0, rx_data_i[ch*W +: W]};
            default: e.rdata = {24'h0, m_tx[ch]};
         endcase
      end

      clr = 0;
      if (ena && wena && !err) begin
         case (off)
            0: begin
               m_ena[ch] = wdata[0];
               m_ien[ch] = wdata[1];
            end
            4: clr = wdata[0];
            default: begin
               m_tx[ch]   = wdata[7:0];
               e.upd[ch]  = 1'b1;
            end
         endcase
      end
      if (clr) m_irq[ch] = 0;
      for (int c = 0; c < CH; c++) if (iset[c]) m_irq[c] = 1;

      e.irq = 0;
      for (int c = 0; c < CH; c++) begin
         e.ena[c] = m_ena[c];
         e.tx[c*W +: W] = m_tx[c];
         if (m_irq[c] && m_ien[c]) e.irq = 1;
      end
      sb_q.push_back(e);

      @(posedge main_clk_i);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rdata"}, mem_rdata_o, 32'h0);
      check({tag, "_rvld"},  {31'h0, mem_rvld_o}, 32'h0);
      check({tag, "_err"},   {31'h0, mem_err_o}, 32'h0);
      check({tag, "_ena"},   {28'h0, ctrl_ena_o}, 32'h0);
      check({tag, "_irq"},   {31'h0, irq_o}, 32'h0);
      check({tag, "_tx"},    tx_data_o, 32'h0);
      check({tag, "_upd"},   {28'h0, tx_upd_o}, 32'h0);
   endtask

   // Monitor: compare every cycle's outputs with the scoreboard entry for it.
   always @(negedge main_clk_i) begin
      exp_t e;
      if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e = sb_q.pop_front();
         check("resp_cycle", cyc, e.cyc);
         check("rvld",  {31'h0, mem_rvld_o}, {31'h0, e.rvld});
         check("err",   {31'h0, mem_err_o},  {31'h0, e.err});
         check("rdata", mem_rdata_o, e.rdata);
         check("ctrl_ena", {28'h0, ctrl_ena_o}, {28'h0, e.ena});
         check("irq_o", {31'h0, irq_o}, {31'h0, e.irq});
         check("tx_data", tx_data_o, e.tx);
         check("tx_upd", {28'h0, tx_upd_o}, {28'h0, e.upd});
      end else if (main_rst_an_i && (mem_rvld_o || mem_err_o)) begin
         check("spurious_resp", {30'h0, mem_rvld_o, mem_err_o}, 32'h0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [12:0] a;
      model_reset();

      // Reset values
      #12;
      check_all_zero("reset");
      @(negedge main_clk_i);
      main_rst_an_i = 1'b1;
      @(posedge main_clk_i);
      #1;

      // Read every legal word after reset
      for (int c = 0; c < CH; c++)
         for (int w = 0; w < 4; w++)
            step(1'b1, 1'b0, 13'(c*16 + w*4), 32'h0, 4'h0);

      // TX write to channel 1, then read it back
      step(1'b1, 1'b1, 13'h01C, 32'hFFFF_FFA5, 4'h0);
      check("tx_ch1_direct", {24'h0, tx_data_o[15:8]}, 32'h0000_00A5);
      check("tx_upd_direct", {28'h0, tx_upd_o}, 32'h0000_0002);
      step(1'b1, 1'b0, 13'h01C, 32'h0, 4'h0);
      check("tx_upd_gone", {28'h0, tx_upd_o}, 32'h0);
      idle();

      // Interrupt: enable ch2, set, read, clear, clear together with set
      step(1'b1, 1'b1, 13'h020, 32'h2, 4'h0);
      step(1'b0, 1'b0, 13'h0, 32'h0, 4'b0100);
      check("irq_set_direct", {31'h0, irq_o}, 32'h1);
      step(1'b1, 1'b0, 13'h024, 32'h0, 4'h0);
      step(1'b1, 1'b1, 13'h024, 32'h1, 4'h0);
      check("irq_clr_direct", {31'h0, irq_o}, 32'h0);
      step(1'b1, 1'b1, 13'h024, 32'h1, 4'b0100);
      check("irq_setwins_direct", {31'h0, irq_o}, 32'h1);
      step(1'b1, 1'b0, 13'h024, 32'h0, 4'h0);

      // Error cases
      step(1'b1, 1'b1, 13'h008, 32'hDEAD_BEEF, 4'h0);
      check("err_rx_write_direct", {31'h0, mem_err_o}, 32'h1);
      step(1'b1, 1'b0, 13'h040, 32'h0, 4'h0);
      step(1'b1, 1'b1, 13'h002, 32'hFFFF_FFFF, 4'h0);
      step(1'b1, 1'b0, 13'h1FF0, 32'h0, 4'h0);
      step(1'b1, 1'b0, 13'h001, 32'h0, 4'h0);
      step(1'b1, 1'b0, 13'h000, 32'h0, 4'h0);

      // Back-to-back write, read-after-write, RX read
      step(1'b1, 1'b1, 13'h000, 32'h1, 4'h0);
      step(1'b1, 1'b0, 13'h000, 32'h0, 4'h0);
      step(1'b1, 1'b0, 13'h038, 32'h0, 4'h0);
      idle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0:       a = 13'($urandom_range(0, 8191));
            1:       a = 13'($urandom_range(0, 5) * 16 + $urandom_range(0, 15));
            default: a = 13'($urandom_range(0, CH-1) * 16 + $urandom_range(0, 3) * 4);
         endcase
         step($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, a, $urandom,
              ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0);
      end

      // Reset in the cycle after a read request
      step(1'b1, 1'b1, 13'h000, 32'h3, 4'h1);
      step(1'b1, 1'b1, 13'h01C, 32'h5A, 4'h0);
      step(1'b1, 1'b0, 13'h01C, 32'h0, 4'h0);
      sb_q.delete();
      main_rst_an_i = 1'b0;
      mem_ena_i     = 1'b0;
      model_reset();
      #1;
      check_all_zero("rst_mid");
      @(negedge main_clk_i);
      @(negedge main_clk_i);
      check_all_zero("rst_hold");
      main_rst_an_i = 1'b1;
      @(posedge main_clk_i);
      #1;
      check_all_zero("rst_after");
      step(1'b1, 1'b0, 13'h000, 32'h0, 4'h0);
      step(1'b1, 1'b0, 13'h01C, 32'h0, 4'h0);
      idle();

      // Drain the scoreboard
      repeat (3) @(negedge main_clk_i);
      check("sb_drained", sb_q.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
